// File: rtl/mux_rr_nx1.sv
// N-channel registered stream mux with valid/ready handshakes; fixed or round-robin selection.
// Defining MUX_PKT_LOCK_EN holds the grant on one channel until its packet's last beat.
module mux_rr_nx1 #(
  parameter int unsigned  N_CH   = 4,
  parameter int unsigned  DATA_W = 8,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mode_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [N_CH-1:0]          valid_i,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  input  logic [N_CH-1:0]          last_i,
  output logic [N_CH-1:0]          ready_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     last_o,
  output logic [SEL_W-1:0]         src_o,
  input  logic                     ready_i
);

  logic [SEL_W-1:0]  w_rr_g;
  logic              w_rr_hit;
  logic              w_fix_vld;
  logic [SEL_W-1:0]  w_g;
  logic              w_gnt_vld;
  logic              w_load;
  logic [DATA_W-1:0] w_data;
  logic              w_last;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [SEL_W-1:0]  r_src;
  logic [SEL_W-1:0]  r_rr_last;

  // Lowest requester above r_rr_last wins; otherwise wrap to the lowest requester overall.
  always_comb begin : rr_search
    w_rr_g   = '0;
    w_rr_hit = 1'b0;
    for (int j = int'(N_CH) - 1; j >= 0; j--) begin
      if (valid_i[j] && (SEL_W'(j) > r_rr_last)) begin
        w_rr_g   = SEL_W'(j);
        w_rr_hit = 1'b1;
      end
    end
    if (!w_rr_hit) begin
      for (int j = int'(N_CH) - 1; j >= 0; j--) begin
        if (valid_i[j]) w_rr_g = SEL_W'(j);
      end
    end
  end

  always_comb begin : fixed_valid
    w_fix_vld = 1'b0;
    for (int j = 0; j < int'(N_CH); j++) begin
      if (sel_i == SEL_W'(j)) w_fix_vld = valid_i[j];
    end
  end

`ifdef MUX_PKT_LOCK_EN
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_ch;
  logic             w_lock_vld;

  always_comb begin : lock_valid
    w_lock_vld = 1'b0;
    for (int j = 0; j < int'(N_CH); j++) begin
      if (r_lock_ch == SEL_W'(j)) w_lock_vld = valid_i[j];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_load) begin
      r_lock    <= !w_last;
      r_lock_ch <= w_g;
    end
  end
`endif

  always_comb begin : grant
    if (mode_i) begin
      w_g       = w_rr_g;
      w_gnt_vld = |valid_i;
    end else begin
      // An out-of-range sel_i matches no channel, so nothing is granted.
      w_g       = sel_i;
      w_gnt_vld = w_fix_vld;
    end
`ifdef MUX_PKT_LOCK_EN
    if (r_lock) begin
      w_g       = r_lock_ch;
      w_gnt_vld = w_lock_vld;
    end
`endif
  end

  assign w_load = (!r_valid || ready_i) && w_gnt_vld;

  always_comb begin : route
    w_data  = '0;
    w_last  = 1'b0;
    ready_o = '0;
    for (int j = 0; j < int'(N_CH); j++) begin
      if (w_g == SEL_W'(j)) begin
        w_data     = data_i[j*DATA_W +: DATA_W];
        w_last     = last_i[j];
        ready_o[j] = w_load;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_src   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_last  <= w_last;
      r_src   <= w_g;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // Only round-robin acceptances move the pointer; fixed-mode traffic leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_last <= SEL_W'(N_CH - 1);
    end else if (w_load && mode_i) begin
      r_rr_last <= w_g;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign last_o  = r_last;
  assign src_o   = r_src;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed self-checking bench for mux_rr_nx1 (N_CH=4, DATA_W=8).
module tb_mux_rr_nx1;
  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   mode_i;
  logic [SEL_W-1:0]       sel_i;
  logic [N_CH-1:0]        valid_i;
  logic [N_CH*DATA_W-1:0] data_i;
  logic [N_CH-1:0]        last_i;
  logic [N_CH-1:0]        ready_o;
  logic                   valid_o;
  logic [DATA_W-1:0]      data_o;
  logic                   last_o;
  logic [SEL_W-1:0]       src_o;
  logic                   ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  mux_rr_nx1 #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W)
  ) u_dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .mode_i  (mode_i),
    .sel_i   (sel_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .src_o   (src_o),
    .ready_i (ready_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          exp_rr[5]  = '{1, 2, 3, 0, 1};
  int          exp_t4[4]  = '{1, 3, 1, 3};
  logic [3:0]  seq_in[4];
  logic [3:0]  seq_out[4];
  logic [3:0]  acc;
  int          n_out;
  int          cnt0;
  logic        acc0;
  int          pk_src[$];
  int          pk_last[$];

  initial begin
    rst_ni  = 1'b0;
    mode_i  = 1'b0;
    sel_i   = '0;
    valid_i = '0;
    last_i  = '0;
    ready_i = 1'b0;
    data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) tick();

    // Reset state
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_last", last_o, 0);
    check_eq("rst_src", src_o, 0);
    check_eq("rst_ready", ready_o, 0);

    // Test 1: load ch2, stall, then reset mid-stall
    rst_ni  = 1'b1;
    sel_i   = 2'd2;
    valid_i = 4'b0100;
    #1;
    check_eq("t1_ready_pre", ready_o, 4'b0100);
    tick();
    check_eq("t1_valid", valid_o, 1);
    check_eq("t1_data", data_o, 8'h12);
    check_eq("t1_src", src_o, 2);
    check_eq("t1_stall_ready", ready_o, 0);
    rst_ni = 1'b0;
    #1;
    check_eq("t1_async_valid", valid_o, 0);
    check_eq("t1_async_data", data_o, 0);
    check_eq("t1_async_src", src_o, 0);
    mode_i  = 1'b1;
    valid_i = 4'hF;
    ready_i = 1'b1;
    tick();
    rst_ni = 1'b1;
    #1;
    check_eq("t1_rr_ready", ready_o, 4'b0001);
    tick();
    check_eq("t1_rr_src", src_o, 0);
    check_eq("t1_rr_data", data_o, 8'h10);

    // Test 3: round-robin over all four channels
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_valid", valid_o, 1);
      check_eq("t3_src", src_o, exp_rr[i]);
      check_eq("t3_data", data_o, 8'h10 + exp_rr[i]);
    end

    // Test 2: fixed select of ch2
    mode_i = 1'b0;
    sel_i  = 2'd2;
    #1;
    check_eq("t2_ready", ready_o, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_src", src_o, 2);
      check_eq("t2_data", data_o, 8'h12);
    end
    valid_i = 4'b1011;
    #1;
    check_eq("t2_noval_ready", ready_o, 0);
    tick();
    check_eq("t2_valid_fall", valid_o, 0);

    // Test 4: only ch1 and ch3 request, then ch3 drops
    pulse_reset();
    mode_i  = 1'b1;
    valid_i = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t4_src", src_o, exp_t4[i]);
    end
    valid_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t4_src_ch1", src_o, 1);
    end

    // Test 5: backpressure mid-stream with per-channel sequence scoreboard
    pulse_reset();
    mode_i  = 1'b1;
    valid_i = 4'hF;
    last_i  = '0;
    for (int k = 0; k < 4; k++) begin
      seq_in[k]  = '0;
      seq_out[k] = '0;
    end
    n_out = 0;
    for (int i = 0; i < 14; i++) begin
      ready_i = !(i >= 4 && i <= 6);
      for (int k = 0; k < 4; k++) data_i[k*8 +: 8] = {4'(k), seq_in[k]};
      #1;
      if (valid_o) begin
        check_eq("t5_src", src_o, n_out % 4);
        check_eq("t5_data", data_o, {4'(n_out % 4), seq_out[n_out % 4]});
        if (ready_i) begin
          seq_out[n_out % 4] = seq_out[n_out % 4] + 4'd1;
          n_out++;
        end else begin
          check_eq("t5_stall_ready", ready_o, 0);
        end
      end
      acc = ready_o & valid_i;
      tick();
      for (int k = 0; k < 4; k++) if (acc[k]) seq_in[k] = seq_in[k] + 4'd1;
    end
    check_eq("t5_count", n_out, 10);

    // Test 6: 3-beat packet on ch0 against a continuously valid ch1
`ifdef MUX_PKT_LOCK_EN
    pk_src  = '{0, 0, 0, 1};
    pk_last = '{0, 0, 1, 0};
`else
    pk_src  = '{0, 1, 0, 1, 0};
    pk_last = '{0, 0, 0, 0, 1};
`endif
    pulse_reset();
    mode_i  = 1'b1;
    ready_i = 1'b1;
    cnt0    = 0;
    n_out   = 0;
    for (int i = 0; i <= pk_src.size(); i++) begin
      valid_i = {2'b00, 1'b1, cnt0 < 3};
      last_i  = {3'b000, cnt0 == 2};
      data_i  = {8'h00, 8'h00, 8'hB1, 8'(8'hA0 + cnt0)};
      #1;
      if (valid_o && n_out < pk_src.size()) begin
        check_eq("t6_src", src_o, pk_src[n_out]);
        check_eq("t6_last", last_o, pk_last[n_out]);
        n_out++;
      end
      acc0 = ready_o[0];
      tick();
      if (acc0) cnt0++;
    end
    check_eq("t6_count", n_out, pk_src.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_nx1.md
Name: mux_rr_nx1

Overview:
Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. Selection is either fixed, taken from sel_i, or round-robin across the requesting channels. It succeeds the combinational 4:1 bit mux and is used wherever several streaming sources share one sink.

Parameters:
N_CH, 4, number of input channels (2..16)
DATA_W, 8, data width per channel in bits
SEL_W, $clog2(N_CH), select/source index width (derived localparam, not overridden)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
mode_i  input  1  0 = fixed select via sel_i, 1 = round-robin
sel_i  input  SEL_W  channel index used in fixed mode
valid_i  input  N_CH  per-channel valid
data_i  input  N_CH*DATA_W  flattened data; channel k occupies bits [k*DATA_W +: DATA_W]
last_i  input  N_CH  per-channel end-of-packet flag
ready_o  output  N_CH  per-channel ready; one-hot or zero
valid_o  output  1  output valid (registered)
data_o  output  DATA_W  output data (registered)
last_o  output  1  output end-of-packet flag (registered)
src_o  output  SEL_W  index of the channel that produced the current output beat (registered)
ready_i  input  1  downstream ready

Behaviour:
- Reset (rst_ni=0): valid_o=0, data_o=0, last_o=0, src_o=0, rr_last=N_CH-1, lock=0. Outputs clear immediately on assertion, without waiting for a clock edge.
- Output stage: single register. Transfer out occurs when valid_o & ready_i.
- load = (!valid_o | ready_i) & gnt_vld.
  - On load: data_o/last_o/src_o <= granted channel values; valid_o <= 1.
  - Else if ready_i: valid_o <= 0.
  - Else: all outputs hold.
- ready_o[g] = gnt_vld & (!valid_o | ready_i), and only for granted channel g; all other bits are 0. The combinational path ready_i -> ready_o is allowed.
- Latency: 1 cycle from input acceptance to valid_o. Throughput is 1 beat/cycle under continuous ready_i.
- Fixed mode:
  - g = sel_i; gnt_vld = valid_i[sel_i].
  - If sel_i >= N_CH, there is no grant and nothing is accepted.
- Round-robin mode:
  - Search from rr_last+1 upward, mod N_CH. g = first channel with valid set; gnt_vld = |valid_i.
  - rr_last <= g on every accepted input beat only.
  - After reset, channel 0 has highest priority.
- rr_last is not updated by fixed-mode transfers. On a switch to round-robin, the search resumes from the last round-robin grant.
- mode_i and sel_i are sampled combinationally every cycle. A change takes effect on the next acceptance.
- No valid_i asserted: no load. valid_o drops after the pending beat is taken.
- Stall (valid_o & !ready_i): data_o, last_o and src_o stay stable; ready_o = 0. No beat is lost or duplicated.
- Reset mid-stall: the pending beat is discarded. After release, arbitration restarts from channel 0.

Optional Feature:
MUX_PKT_LOCK_EN
- Defined:
  - Acceptance of a beat with last_i=0 sets lock=1 and lock_ch=g.
  - While lock=1, grant is forced to lock_ch regardless of mode_i, sel_i and the valid_i of other channels.
  - Acceptance of a lock_ch beat with last_i=1 clears lock.
  - Packets from different channels never interleave on the output.
- Undefined:
  - There is no lock state; the grant is re-evaluated on every beat.
  - last_i is passed through to last_o only.
  - Port list is identical in both builds.

Test Plan:
1. Reset while valid_o=1 and ready_i=0 (ch2 data 0x12) -> valid_o/data_o/src_o go to 0 before the next edge. After release, RR with all valid grants ch0 first.
2. Fixed mode, sel_i=2, all valid, data ch k = 0x10+k, ready_i=1 -> ready_o=4'b0100; data_o=0x12, src_o=2 every cycle from cycle 1. With sel_i=2 and valid_i[2]=0 -> ready_o=0 and valid_o falls.
3. RR mode, all four valid continuously, ready_i=1 -> src_o sequence 0,1,2,3,0,1; one beat per cycle.
4. RR mode, only ch1 and ch3 valid -> src_o 1,3,1,3. Deassert ch3 -> 1,1,1.
5. Backpressure: ready_i=0 for 3 cycles mid-stream -> valid_o=1 held, data_o constant, ready_o=0. On resume, the sequence continues with no gaps or duplicates (scoreboard per channel).
6. RR, ch0 sends a 3-beat packet (last on beat 3) with ch1 continuously valid:
   - MUX_PKT_LOCK_EN defined -> src_o 0,0,0,1.
   - Undefined -> 0,1,0,1,0; last_o=1 only on ch0's third beat.
